// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel edge-magnitude filter.
// Raster-order pixels in, same-size magnitude frame out, zero-padded borders.
// The scan walks (COL_NUM+1) x (ROW_NUM+1) steps; the extra column and row
// are pad steps that push zeros so the last row/column centres can be emitted.
// Optional build macro SOBEL_THRESHOLD_EN adds a run-time threshold input that
// turns the magnitude into a binary edge map.
module sobel_stream_filter #(
    parameter int PIXEL_W = 8,
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W+2:0] out_pixel,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_eol,
    output logic               out_eof,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIXEL_W+2:0] threshold,
`endif
    output logic               busy
);

    localparam int SW    = PIXEL_W + 4;
    localparam int MW    = PIXEL_W + 3;
    localparam int IDX_W = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam logic [COORD_W-1:0] COL_PAD  = COORD_W'(COL_NUM);
    localparam logic [COORD_W-1:0] ROW_PAD  = COORD_W'(ROW_NUM);
    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COL_NUM - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROW_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
`ifdef SOBEL_THRESHOLD_EN
    logic [MW-1:0]        thr_q, thr_d;
`endif
    logic [COORD_W-1:0]   sx_q, sx_d, sy_q, sy_d;
    logic [PIXEL_W-1:0]   lb0_q [COL_NUM];
    logic [PIXEL_W-1:0]   lb0_d [COL_NUM];
    logic [PIXEL_W-1:0]   lb1_q [COL_NUM];
    logic [PIXEL_W-1:0]   lb1_d [COL_NUM];
    logic [PIXEL_W-1:0]   wl_q [3];
    logic [PIXEL_W-1:0]   wl_d [3];
    logic [PIXEL_W-1:0]   wc_q [3];
    logic [PIXEL_W-1:0]   wc_d [3];
    logic                 out_valid_q, out_valid_d;
    logic [MW-1:0]        out_pixel_q, out_pixel_d;
    logic [COORD_W-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    logic                 out_eol_q, out_eol_d, out_eof_q, out_eof_d;

    logic                 in_step, can_adv, step_fire;
    logic [IDX_W-1:0]     idx;
    logic [PIXEL_W-1:0]   nc [3];
    logic signed [SW-1:0] gx, gy;
    logic [MW-1:0]        mag, pix_new;

    // 1-2-1 weighted sum of three pixels, zero-extended to signed
    function automatic logic signed [SW-1:0] wsum(input logic [PIXEL_W-1:0] a,
                                                  input logic [PIXEL_W-1:0] b,
                                                  input logic [PIXEL_W-1:0] c);
        logic signed [SW-1:0] ea, eb, ec;
        ea = $signed({4'b0000, a});
        eb = $signed({4'b0000, b});
        ec = $signed({4'b0000, c});
        return ea + eb + eb + ec;
    endfunction

    // |v| never exceeds 4*(2^PIXEL_W-1), so truncation to MW bits is lossless
    function automatic logic [MW-1:0] abs_w(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] a;
        a = v[SW-1] ? -v : v;
        return MW'(a);
    endfunction

    // Sum of magnitudes fits MW bits; mode 1 picks the larger component
    function automatic logic [MW-1:0] combine(input logic m, input logic [MW-1:0] ax,
                                              input logic [MW-1:0] ay);
        if (m) return (ax > ay) ? ax : ay;
        return ax + ay;
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;

    // Scan step handshake, column assembly, Sobel arithmetic and output load
    always_comb begin
        in_step   = (sx_q < COL_PAD) && (sy_q < ROW_PAD);
        can_adv   = !out_valid_q || out_ready;
        in_ready  = (state_q == S_RUN) && in_step && can_adv;
        step_fire = (in_ready && in_valid) || (!in_step && can_adv && (state_q != S_IDLE));

        // New rightmost column: rows sy-2, sy-1, sy; rows -1 and ROW_NUM and column COL_NUM read 0
        idx   = sx_q[IDX_W-1:0];
        nc[0] = '0;
        nc[1] = '0;
        nc[2] = '0;
        if (sx_q < COL_PAD) begin
            if (sy_q >= COORD_W'(2)) nc[0] = lb1_q[idx];
            if (sy_q != '0)          nc[1] = lb0_q[idx];
            if (sy_q < ROW_PAD)      nc[2] = in_pixel;
        end

        gx  = wsum(nc[0], nc[1], nc[2]) - wsum(wl_q[0], wl_q[1], wl_q[2]);
        gy  = wsum(wl_q[2], wc_q[2], nc[2]) - wsum(wl_q[0], wc_q[0], nc[0]);
        mag = combine(mode_q, abs_w(gx), abs_w(gy));
`ifdef SOBEL_THRESHOLD_EN
        pix_new = (mag >= thr_q) ? '1 : '0;
`else
        pix_new = mag;
`endif

        sx_d        = sx_q;
        sy_d        = sy_q;
        lb0_d       = lb0_q;
        lb1_d       = lb1_q;
        wl_d        = wl_q;
        wc_d        = wc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_pixel_d = out_pixel_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;

        if (step_fire) begin
            if (sx_q < COL_PAD) begin
                lb1_d[idx] = nc[1];
                lb0_d[idx] = nc[2];
            end
            wl_d = wc_q;
            wc_d = nc;
            if (sx_q == COL_PAD) begin
                sx_d = '0;
                sy_d = (sy_q == ROW_PAD) ? '0 : sy_q + COORD_W'(1);
            end else begin
                sx_d = sx_q + COORD_W'(1);
            end
            if ((sx_q != '0) && (sy_q != '0)) begin
                out_valid_d = 1'b1;
                out_pixel_d = pix_new;
                out_x_d     = sx_q - COORD_W'(1);
                out_y_d     = sy_q - COORD_W'(1);
                out_eol_d   = (sx_q == COL_PAD);
                out_eof_d   = (sx_q == COL_PAD) && (sy_q == ROW_PAD);
            end
        end
    end

    // Frame control FSM; mode (and threshold) captured on frame start
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
`ifdef SOBEL_THRESHOLD_EN
        thr_d   = thr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                    mode_d  = mode;
`ifdef SOBEL_THRESHOLD_EN
                    thr_d   = threshold;
`endif
                end
            end
            S_RUN: begin
                if (in_ready && in_valid && (sx_q == COL_LAST) && (sy_q == ROW_LAST))
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (out_valid_q && out_ready && out_eof_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, scan, line buffer, window and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
`ifdef SOBEL_THRESHOLD_EN
            thr_q   <= '0;
`endif
            sx_q    <= '0;
            sy_q    <= '0;
            for (int i = 0; i < COL_NUM; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int j = 0; j < 3; j++) begin
                wl_q[j] <= '0;
                wc_q[j] <= '0;
            end
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
`ifdef SOBEL_THRESHOLD_EN
            thr_q   <= thr_d;
`endif
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            lb0_q   <= lb0_d;
            lb1_q   <= lb1_d;
            wl_q    <= wl_d;
            wc_q    <= wc_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter on a 4x3 frame: the driver pushes
// the reference frame result into a queue, the monitor pops on each accepted
// output. Reference is a direct zero-padded 3x3 convolution over an array.
module tb_sobel_stream_filter;

    localparam int PW  = 8;
    localparam int COL = 4;
    localparam int ROW = 3;
    localparam int CW  = 11;
    localparam int ALL_ONES = (1 << (PW + 3)) - 1;

    typedef struct {
        int pix;
        int x;
        int y;
        int eof;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [PW+2:0] out_pixel;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
`ifdef SOBEL_THRESHOLD_EN
    logic [PW+2:0] threshold;
`endif

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t expq[$];
    int   img[ROW][COL];
    int   got[ROW][COL];
    int   gold[ROW][COL];
    int   frame_outs;
    int   eof_cnt;
    bit   bp_on = 1'b0;
    int   thr_val = 500;

    sobel_stream_filter #(
        .PIXEL_W(PW), .COL_NUM(COL), .ROW_NUM(ROW), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_x(out_x), .out_y(out_y), .out_eol(out_eol), .out_eof(out_eof),
`ifdef SOBEL_THRESHOLD_EN
        .threshold(threshold),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    endtask

    function automatic int px(int x, int y);
        if (x < 0 || x >= COL || y < 0 || y >= ROW) return 0;
        return img[y][x];
    endfunction

    function automatic int ref_mag(int x, int y, int m);
        int gx, gy, ax, ay, r;
        gx = (px(x+1, y-1) + 2*px(x+1, y) + px(x+1, y+1))
           - (px(x-1, y-1) + 2*px(x-1, y) + px(x-1, y+1));
        gy = (px(x-1, y+1) + 2*px(x, y+1) + px(x+1, y+1))
           - (px(x-1, y-1) + 2*px(x, y-1) + px(x+1, y-1));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        r  = m ? ((ax > ay) ? ax : ay) : ax + ay;
`ifdef SOBEL_THRESHOLD_EN
        r  = (r >= thr_val) ? ALL_ONES : 0;
`endif
        return r;
    endfunction

    function automatic void fill(int pat);
        for (int y = 0; y < ROW; y++)
            for (int x = 0; x < COL; x++)
                case (pat)
                    0:       img[y][x] = 100;
                    1:       img[y][x] = (x >= 2) ? 200 : 0;
                    2:       img[y][x] = (y == 2) ? 255 : 0;
                    3:       img[y][x] = int'($urandom_range(0, 255));
                    default: img[y][x] = int'($urandom_range(0, 1)) * 255;
                endcase
    endfunction

    // Output backpressure: free-running or a 1-on/2-off pattern
    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                out_ready = (k % 3 == 0);
                k++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted output, checks stall behaviour
    initial begin
        exp_t e;
        bit   prev_stall;
        int   h_pix, h_x, h_y, h_eof;
        prev_stall = 1'b0;
        h_pix = 0; h_x = 0; h_y = 0; h_eof = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_pix", int'(out_pixel), h_pix);
                    chk("stall_xy", int'(out_x) * 100 + int'(out_y), h_x * 100 + h_y);
                    chk("stall_eof", int'(out_eof), h_eof);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        total_cnt++;
                        $display("FAIL spurious_out: output (%0d,%0d)=%0d with nothing expected",
                                 out_x, out_y, out_pixel);
                    end else begin
                        e = expq.pop_front();
                        chk("pix", int'(out_pixel), e.pix);
                        chk("x", int'(out_x), e.x);
                        chk("y", int'(out_y), e.y);
                        chk("eol", int'(out_eol), int'(e.x == COL - 1));
                        chk("eof", int'(out_eof), e.eof);
                    end
                    if (out_x < CW'(COL) && out_y < CW'(ROW)) got[out_y][out_x] = int'(out_pixel);
                    frame_outs++;
                    if (out_eof) eof_cnt++;
                end else if (out_valid) begin
                    chk("stall_in_ready", int'(in_ready), 0);
                end
                prev_stall = out_valid && !out_ready;
                h_pix = int'(out_pixel);
                h_x   = int'(out_x);
                h_y   = int'(out_y);
                h_eof = int'(out_eof);
            end
        end
    end

    task automatic start_frame(input int m);
        @(posedge clk);
        #1;
        mode = m[0];
`ifdef SOBEL_THRESHOLD_EN
        threshold = (PW+3)'(thr_val);
`endif
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        mode = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_pixel(input int v);
        int cyc;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pixel = PW'(v);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (in_ready || cyc >= 200) break;
            cyc++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int pat, input int m, input bit bp);
        int cyc;
        fill(pat);
        frame_outs = 0;
        eof_cnt = 0;
        for (int y = 0; y < ROW; y++)
            for (int x = 0; x < COL; x++) begin
                got[y][x] = -1;
                expq.push_back('{ref_mag(x, y, m), x, y, int'(x == COL - 1 && y == ROW - 1)});
            end
        bp_on = bp;
        start_frame(m);
        for (int y = 0; y < ROW; y++)
            for (int x = 0; x < COL; x++)
                drive_pixel(img[y][x]);
        in_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_done", int'(busy), 0);
        @(negedge clk);
        chk("frame_outs", frame_outs, COL * ROW);
        chk("eof_count", eof_cnt, 1);
        chk("queue_empty", expq.size(), 0);
        expq.delete();
        bp_on = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        mode = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
`ifdef SOBEL_THRESHOLD_EN
        threshold = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_xy", int'(out_x) + int'(out_y), 0);
        chk("rst_eol_eof", int'(out_eol) + int'(out_eof), 0);
        rst_n = 1'b1;

        // Uniform frame, free running
        run_frame(0, 0, 1'b0);
`ifdef SOBEL_THRESHOLD_EN
        chk("thr_0_0", got[0][0], ALL_ONES);
        chk("thr_1_0", got[0][1], 0);
        chk("thr_1_1", got[1][1], 0);
`else
        chk("uni_0_0", got[0][0], 600);
        chk("uni_1_0", got[0][1], 400);
        chk("uni_1_1", got[1][1], 0);
        chk("uni_0_1", got[1][0], 400);
        chk("uni_3_2", got[2][3], 600);
`endif
        gold = got;

        // Same frame under backpressure must match the free-running result
        run_frame(0, 0, 1'b1);
        for (int y = 0; y < ROW; y++)
            for (int x = 0; x < COL; x++)
                chk("bp_vs_free", got[y][x], gold[y][x]);

`ifndef SOBEL_THRESHOLD_EN
        run_frame(1, 0, 1'b0);
        chk("vstep_m0", got[1][1], 800);
        run_frame(1, 1, 1'b0);
        chk("vstep_m1", got[1][1], 800);
        run_frame(2, 0, 1'b0);
        chk("hstep_m0", got[1][1], 1020);
`endif

        // Abort a frame with reset after 5 inputs
        fill(0);
        start_frame(0);
        for (int i = 0; i < 5; i++) drive_pixel(100);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(0, 0, 1'b0);
        for (int y = 0; y < ROW; y++)
            for (int x = 0; x < COL; x++)
                chk("post_abort", got[y][x], gold[y][x]);

        // Random and extreme-valued frames, random mode and backpressure
        for (int i = 0; i < 8; i++) begin
`ifdef SOBEL_THRESHOLD_EN
            thr_val = int'($urandom_range(0, 2047));
`endif
            run_frame(3 + (i % 2), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

endmodule
